linebuf_col3_ctrl: RTL

LINEBUF_COL3_CTRL -- requirements
Module: linebuf_col3_ctrl

---
 rtl/linebuf_pkg.sv | 15 +
 rtl/linebuf_col3_ctrl_ram_line_sp.sv | 32 +++
 rtl/linebuf_col3_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/linebuf_pkg.sv
// Shared state encoding and default sizes for the 3-row column line buffer.
package linebuf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int LB_DATA_WIDTH = 16;
  localparam int LB_ADDR_WIDTH = 11;
  localparam int LB_LINE_LEN   = 1920;

  localparam logic [1:0] ROW_FULL = 2'd2;

endpackage

// File: rtl/linebuf_col3_ctrl_ram_line_sp.sv
// Single-port line memory: registered read when not writing, read data held during a write.
module ram_line_sp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 1920
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[addr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (!w_en) begin
      r_data <= mem[addr];
    end
  end

endmodule

// File: rtl/linebuf_col3_ctrl.sv
// Column builder: emits current pixel plus the same column from the two previous lines.
module linebuf_col3_ctrl
  import linebuf_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int LINE_LEN   = LB_LINE_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_p0,
  output logic [DATA_WIDTH-1:0] out_p1,
  output logic [DATA_WIDTH-1:0] out_p2,
  output logic [ADDR_WIDTH-1:0] out_col,
  output logic                  out_eol,
  output logic                  out_rows_ok,
  output logic                  state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_LEN - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] pix_q;
  logic [ADDR_WIDTH-1:0] col;
  logic [1:0]            row;
  logic [DATA_WIDTH-1:0] a_rd;
  logic [DATA_WIDTH-1:0] b_rd;
  logic                  mem_w_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  xfer;

  // Handshake: a pixel moves when in_valid && in_ready on a rising edge; in_ready is
  // high only in IDLE and does not depend on in_valid, so a held in_valid sees 1,0,1,0.
  assign in_ready  = (state == IDLE);
  assign xfer      = in_valid && in_ready;
  assign state_dbg = (state == WRITE);

  // Reset gates the write strobe so a write in flight is dropped on the reset edge.
  assign mem_w_en = (state == WRITE) && rst_n;
  assign mem_addr = (xfer && in_sof) ? '0 : col;

  ram_line_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (LINE_LEN)
  ) u_line_a (
    .clk   (clk),
    .rst_n (rst_n),
    .w_en  (mem_w_en),
    .addr  (mem_addr),
    .w_data(pix_q),
    .r_data(a_rd)
  );

  // Line B is fed from line A's read data, so the two memories form a 2-line shift.
  ram_line_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (LINE_LEN)
  ) u_line_b (
    .clk   (clk),
    .rst_n (rst_n),
    .w_en  (mem_w_en),
    .addr  (mem_addr),
    .w_data(a_rd),
    .r_data(b_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pix_q       <= '0;
      col         <= '0;
      row         <= '0;
      out_valid   <= 1'b0;
      out_p0      <= '0;
      out_p1      <= '0;
      out_p2      <= '0;
      out_col     <= '0;
      out_eol     <= 1'b0;
      out_rows_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (xfer) begin
            pix_q <= in_data;
            if (in_sof) begin
              col <= '0;
              row <= '0;
            end
            state <= WRITE;
          end
        end
        WRITE: begin
          out_valid   <= 1'b1;
          out_p0      <= pix_q;
          out_p1      <= a_rd;
          out_p2      <= b_rd;
          out_col     <= col;
          out_eol     <= (col == LAST_COL);
          out_rows_ok <= (row == ROW_FULL);
          if (col == LAST_COL) begin
            col <= '0;
            if (row != ROW_FULL) begin
              row <= row + 2'd1;
            end
          end else begin
            col <= col + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
